// File: rtl/echo_delay_ctrl.sv
// Feedback-echo controller driving both ports of a true-dual-port delay-line RAM.
// Optional feature: define ECHO_RAM_CLEAR_EN to zero the delay line after every reset.
module echo_delay_ctrl #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic [ADDR_WIDTH-1:0] delay_len,
  input  logic [7:0]            fb_gain,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  out_valid,
  output logic                  overrun,
  output logic                  ena,
  output logic                  wea,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [DATA_WIDTH-1:0] dia,
  output logic                  enb,
  output logic                  web,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dob
);

  localparam int PW = DATA_WIDTH + 9;
  localparam logic signed [PW-1:0] MAXV = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {CLEAR, IDLE, READ, CALC, WRITE} state_t;

`ifdef ECHO_RAM_CLEAR_EN
  localparam state_t RST_STATE = CLEAR;
  logic [ADDR_WIDTH:0] clr_cnt;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0]        wr_ptr;
  logic signed [DATA_WIDTH-1:0] sample_q;
  logic [7:0]                   gain_q;
  logic                         accept;

  logic signed [PW-1:0]         dob_x, gain_x, prod, echo, sum_w;
  logic [DATA_WIDTH-1:0]        res;

  assign web    = 1'b0;
  // ready is registered, so it also masks the first IDLE cycle straight out of reset
  assign accept = (state == IDLE) && ready && sample_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RST_STATE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
`ifdef ECHO_RAM_CLEAR_EN
      CLEAR:   if (clr_cnt == (ADDR_WIDTH+1)'(DEPTH)) next_state = IDLE;
`else
      CLEAR:   next_state = IDLE;
`endif
      IDLE:    if (accept) next_state = READ;
      READ:    next_state = CALC;
      CALC:    next_state = WRITE;
      WRITE:   next_state = IDLE;
      default: next_state = RST_STATE;
    endcase
  end

  // Mix is evaluated at full product width so saturation sees every carry bit
  always_comb begin
    dob_x  = {{(PW-DATA_WIDTH){dob[DATA_WIDTH-1]}}, dob};
    gain_x = {{(PW-8){1'b0}}, gain_q};
    prod   = dob_x * gain_x;
    echo   = prod >>> 8;
    sum_w  = {{(PW-DATA_WIDTH){sample_q[DATA_WIDTH-1]}}, sample_q} + echo;
    if (sum_w > MAXV)      res = MAXV[DATA_WIDTH-1:0];
    else if (sum_w < MINV) res = MINV[DATA_WIDTH-1:0];
    else                   res = sum_w[DATA_WIDTH-1:0];
  end

  // Outputs are registered on the transition into the state they belong to
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready      <= 1'b0;
      sample_out <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      ena        <= 1'b0;
      wea        <= 1'b0;
      enb        <= 1'b0;
      addra      <= '0;
      addrb      <= '0;
      dia        <= '0;
      wr_ptr     <= '0;
      sample_q   <= '0;
      gain_q     <= '0;
`ifdef ECHO_RAM_CLEAR_EN
      clr_cnt    <= '0;
`endif
    end else begin
      ready     <= (next_state == IDLE);
      out_valid <= 1'b0;
      ena       <= 1'b0;
      wea       <= 1'b0;
      enb       <= 1'b0;
      if (sample_valid && !ready) overrun <= 1'b1;
      unique case (state)
`ifdef ECHO_RAM_CLEAR_EN
        CLEAR: begin
          if (clr_cnt != (ADDR_WIDTH+1)'(DEPTH)) begin
            ena     <= 1'b1;
            wea     <= 1'b1;
            addra   <= clr_cnt[ADDR_WIDTH-1:0];
            dia     <= '0;
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
`endif
        IDLE: begin
          if (accept) begin
            sample_q <= sample_in;
            gain_q   <= fb_gain;
            enb      <= 1'b1;
            addrb    <= wr_ptr - delay_len;
          end
        end
        CALC: begin
          ena        <= 1'b1;
          wea        <= 1'b1;
          addra      <= wr_ptr;
          dia        <= res;
          sample_out <= res;
          out_valid  <= 1'b1;
          wr_ptr     <= wr_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Directed bench for echo_delay_ctrl with a behavioural read-first dual-port RAM.
// Covers both builds of ECHO_RAM_CLEAR_EN.
module tb_echo_delay_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] sample_in;
  logic        sample_valid;
  logic [3:0]  delay_len;
  logic [7:0]  fb_gain;
  logic        ready, out_valid, overrun, ena, wea, enb, web;
  logic [23:0] sample_out, dia, dob;
  logic [3:0]  addra, addrb;

  logic [23:0] mem [16];
  logic        ram_wipe;
  logic [23:0] ram_wipe_val;

  int          nvec = 0;
  int          nerr = 0;
  logic [3:0]  exp_wp;

  typedef struct {
    logic        rst;
    logic [23:0] smp;
    logic [7:0]  gain;
    logic [3:0]  dly;
    logic [23:0] exp;
  } vec_t;
  vec_t vt[$];

  always #5 clk = ~clk;

  echo_delay_ctrl #(.DEPTH(16), .ADDR_WIDTH(4), .DATA_WIDTH(24)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .delay_len(delay_len), .fb_gain(fb_gain), .ready(ready), .sample_out(sample_out),
    .out_valid(out_valid), .overrun(overrun), .ena(ena), .wea(wea), .addra(addra),
    .dia(dia), .enb(enb), .web(web), .addrb(addrb), .dob(dob)
  );

  always @(posedge clk) begin
    if (ram_wipe) begin
      for (int i = 0; i < 16; i++) mem[i] <= ram_wipe_val;
    end else if (ena && wea) begin
      mem[addra] <= dia;
    end
    if (enb) dob <= mem[addrb];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk(nm, {ready, sample_out, out_valid, overrun, ena, wea, enb, addra, addrb, dia}, 64'h0);
  endtask

  task automatic release_rst();
    rst_n = 1'b1;
`ifdef ECHO_RAM_CLEAR_EN
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("clear%0d", i), {ready, ena, wea, enb, addra, dia},
          {1'b0, 1'b1, 1'b1, 1'b0, 4'(i), 24'h0});
    end
`endif
    tick();
    chk("ready_after_rst", {ready, ena, wea}, 3'b100);
    exp_wp = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
`ifndef ECHO_RAM_CLEAR_EN
    ram_wipe     = 1'b1;
    ram_wipe_val = '0;
`endif
    tick();
    ram_wipe = 1'b0;
    tick();
    chk_reset_vals("reset_vals");
    release_rst();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin
      tick();
      n++;
    end
    chk("ready_wait", ready, 1);
  endtask

  task automatic apply_vec(input logic [23:0] smp, input logic [7:0] gain,
                           input logic [3:0] dly, input logic [23:0] exp);
    int lat = 1;
    logic [3:0] ra;
    wait_ready();
    ra           = exp_wp - dly;
    sample_in    = smp;
    fb_gain      = gain;
    delay_len    = dly;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    sample_in    = 24'hDEAD00;
    fb_gain      = 8'hFF;
    delay_len    = dly + 4'd3;
    chk("rd_port", {enb, addrb}, {1'b1, ra});
    while (!out_valid && lat < 6) begin
      tick();
      lat++;
    end
    chk("latency", lat, 3);
    chk("sample_out", sample_out, exp);
    chk("wr_port", {ena, wea, addra, dia}, {1'b1, 1'b1, exp_wp, exp});
    exp_wp++;
    tick();
    chk("pulse", {out_valid, ena, wea, enb}, 4'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    delay_len    = '0;
    fb_gain      = '0;
    exp_wp       = '0;
    ram_wipe     = 1'b1;
`ifdef ECHO_RAM_CLEAR_EN
    ram_wipe_val = 24'h5A5A5A;
`else
    ram_wipe_val = 24'h000000;
`endif
    tick();
    ram_wipe = 1'b0;
    tick();
    chk_reset_vals("reset_vals");
    chk("web", web, 0);
    release_rst();

    // impulse response through a 4-sample delay at gain 0.5
    vt.push_back('{1'b0, 24'h100000, 8'd128, 4'd4, 24'h100000});
    for (int i = 0; i < 3; i++) vt.push_back('{1'b0, 24'h0, 8'd128, 4'd4, 24'h0});
    vt.push_back('{1'b0, 24'h0, 8'd128, 4'd4, 24'h080000});
    for (int i = 0; i < 3; i++) vt.push_back('{1'b0, 24'h0, 8'd128, 4'd4, 24'h0});
    vt.push_back('{1'b0, 24'h0, 8'd128, 4'd4, 24'h040000});
    // saturation at both rails
    vt.push_back('{1'b1, 24'h7FFFFF, 8'd255, 4'd1, 24'h7FFFFF});
    for (int i = 0; i < 3; i++) vt.push_back('{1'b0, 24'h7FFFFF, 8'd255, 4'd1, 24'h7FFFFF});
    vt.push_back('{1'b1, 24'h800000, 8'd255, 4'd1, 24'h800000});
    for (int i = 0; i < 3; i++) vt.push_back('{1'b0, 24'h800000, 8'd255, 4'd1, 24'h800000});
    // zero gain is a pass-through
    vt.push_back('{1'b1, 24'h123456, 8'd0, 4'd1, 24'h123456});
    vt.push_back('{1'b0, 24'hABCDEF, 8'd0, 4'd1, 24'hABCDEF});
    // echo plus new input; arithmetic shift floors negative echoes
    vt.push_back('{1'b1, 24'h000100, 8'd64, 4'd1, 24'h000100});
    vt.push_back('{1'b0, 24'h000010, 8'd64, 4'd1, 24'h000050});
    vt.push_back('{1'b1, 24'hFFFFFF, 8'd128, 4'd1, 24'hFFFFFF});
    vt.push_back('{1'b0, 24'h000000, 8'd128, 4'd1, 24'hFFFFFF});
    vt.push_back('{1'b1, 24'hFFFF00, 8'd128, 4'd1, 24'hFFFF00});
    vt.push_back('{1'b0, 24'h000000, 8'd128, 4'd1, 24'hFFFF80});

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].rst) do_reset();
      apply_vec(vt[i].smp, vt[i].gain, vt[i].dly, vt[i].exp);
    end

    // back-to-back strobes: second is dropped and overrun sticks
    begin
      int pulses = 0;
      logic [23:0] got = '0;
      do_reset();
      wait_ready();
      sample_in    = 24'h111111;
      fb_gain      = 8'd0;
      delay_len    = 4'd1;
      sample_valid = 1'b1;
      tick();
      sample_in = 24'h222222;
      tick();
      sample_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
        if (out_valid) begin
          pulses++;
          got = sample_out;
        end
        tick();
      end
      chk("ovr_pulses", pulses, 1);
      chk("ovr_value", got, 24'h111111);
      chk("ovr_flag", overrun, 1);
      exp_wp++;
      apply_vec(24'h000001, 8'd0, 4'd1, 24'h000001);
      chk("ovr_sticky", overrun, 1);
    end

    // reset while in CALC discards the sample
    wait_ready();
    sample_in    = 24'h333333;
    fb_gain      = 8'd0;
    delay_len    = 4'd1;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk_reset_vals("rst_in_calc");
    tick();
    chk_reset_vals("rst_held");
    release_rst();

    // delay_len=0 reaches back a full line, across the write-pointer wrap
    do_reset();
    apply_vec(24'h200000, 8'd128, 4'd0, 24'h200000);
    for (int i = 0; i < 15; i++) apply_vec(24'h0, 8'd128, 4'd0, 24'h0);
    apply_vec(24'h0, 8'd128, 4'd0, 24'h100000);
    apply_vec(24'h0, 8'd128, 4'd0, 24'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
